dnn_seq_ctrl: RTL and testbench

//  Sequencing controller for the 4-4-2 ReLU network: layer1 4x4 FC, ReLU, layer2 4x2 FC.
//  It time-multiplexes one signed multiplier and one accumulator over all 24 MACs.

---
 rtl/dnn_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_dnn_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_seq_ctrl.sv
// Sequencing controller for the 4-4-2 ReLU network: one signed multiplier and one
// accumulator are time-shared over the 16 layer-1 MACs and the 8 layer-2 MACs.
module dnn_seq_ctrl #(
  parameter  int DW = 5,
  localparam int A1 = 2*DW + 2,
  localparam int OW = 3*DW + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*DW-1:0]      x_flat,
  input  logic [16*DW-1:0]     w1_flat,
  input  logic [8*DW-1:0]      w2_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out0,
  output logic signed [OW-1:0] out1,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] x_q  [4],  x_d  [4];
  logic signed [DW-1:0] w1_q [16], w1_d [16];
  logic signed [DW-1:0] w2_q [8],  w2_d [8];
  logic [A1-1:0]        h_q  [4],  h_d  [4];
  logic signed [OW-1:0] out0_q, out0_d, out1_q, out1_d;

  logic signed [OW-1:0] mul_a, mul_b, prod, sum;
  logic [1:0]           l1_i, l1_j, l2_j;
  logic                 l2_k;

  // Shared MAC. Operands are widened to OW so the truncated product is exact;
  // hidden values are non-negative and therefore zero-extended.
  always_comb begin
    l1_i  = cnt_q[1:0];
    l1_j  = cnt_q[3:2];
    l2_j  = cnt_q[1:0];
    l2_k  = cnt_q[2];
    mul_a = '0;
    mul_b = '0;
    if (state_q == L1) begin
      mul_a = OW'(x_q[l1_i]);
      mul_b = OW'(w1_q[{l1_i, l1_j}]);
    end else if (state_q == L2) begin
      mul_a = OW'(h_q[l2_j]);
      mul_b = OW'(w2_q[{l2_j, l2_k}]);
    end
    prod = mul_a * mul_b;
    sum  = acc_q + prod;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    h_d     = h_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 4; i++)  x_d[i]  = x_flat[i*DW +: DW];
          for (int i = 0; i < 16; i++) w1_d[i] = w1_flat[i*DW +: DW];
          for (int i = 0; i < 8; i++)  w2_d[i] = w2_flat[i*DW +: DW];
          cnt_d   = '0;
          acc_d   = '0;
          state_d = L1;
        end
      end
      L1: begin
        cnt_d = cnt_q + 4'd1;
        if (l1_i == 2'd3) begin
          h_d[l1_j] = sum[OW-1] ? '0 : sum[A1-1:0];
          acc_d     = '0;
        end else begin
          acc_d = sum;
        end
        if (cnt_q == 4'd15) begin
          cnt_d   = '0;
          state_d = L2;
        end
      end
      L2: begin
        cnt_d = cnt_q + 4'd1;
        if (l2_j == 2'd3) begin
          if (l2_k) out1_d = sum;
          else      out0_d = sum;
          acc_d = '0;
        end else begin
          acc_d = sum;
        end
        if (cnt_q == 4'd7) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      for (int i = 0; i < 4; i++)  x_q[i]  <= '0;
      for (int i = 0; i < 16; i++) w1_q[i] <= '0;
      for (int i = 0; i < 8; i++)  w2_q[i] <= '0;
      for (int i = 0; i < 4; i++)  h_q[i]  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      x_q     <= x_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      h_q     <= h_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out0      = out0_q;
  assign out1      = out1_q;

endmodule

// File: tb/tb_dnn_seq_ctrl.sv
// Self-checking bench for dnn_seq_ctrl: directed network cases plus random
// back-to-back jobs compared against a plain-arithmetic network model.
module tb_dnn_seq_ctrl;

  localparam int DW = 5;
  localparam int OW = 3*DW + 2;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b1;
  logic [4*DW-1:0]      x_flat    = '0;
  logic [16*DW-1:0]     w1_flat   = '0;
  logic [8*DW-1:0]      w2_flat   = '0;
  logic                 in_ready, out_valid, busy;
  logic signed [OW-1:0] out0, out1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dnn_seq_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_flat    (x_flat),
    .w1_flat   (w1_flat),
    .w2_flat   (w2_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .busy      (busy)
  );

  // Network evaluated directly: hidden = ReLU(sum x*w1), out = sum hidden*w2.
  function automatic void ref_model(input logic [19:0] xf, input logic [79:0] w1f,
                                    input logic [39:0] w2f, output int o0, output int o1);
    int h [4];
    int s, xi, wi;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int i = 0; i < 4; i++) begin
        xi = int'($signed(xf[i*5 +: 5]));
        wi = int'($signed(w1f[(4*i+j)*5 +: 5]));
        s += xi * wi;
      end
      h[j] = (s < 0) ? 0 : s;
    end
    o0 = 0;
    o1 = 0;
    for (int j = 0; j < 4; j++) begin
      o0 += h[j] * int'($signed(w2f[(2*j)*5 +: 5]));
      o1 += h[j] * int'($signed(w2f[(2*j+1)*5 +: 5]));
    end
  endfunction

  task automatic run_job(input logic [19:0] xf, input logic [79:0] w1f, input logic [39:0] w2f,
                         input int e0, input int e1, input int hold, input string name,
                         output longint t_acc);
    logic signed [OW-1:0] exp0, exp1;
    int  n;
    bit  seen;
    exp0  = e0[OW-1:0];
    exp1  = e1[OW-1:0];
    t_acc = 0;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("[TB] FAIL %s in_ready_wait: got %b, expected 1 within 60 cycles", name, in_ready);
      return;
    end
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    x_flat    = xf;
    w1_flat   = w1f;
    w2_flat   = w2f;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    in_valid = 1'b0;
    x_flat   = 20'($urandom);
    w1_flat  = {w1_flat[40:0], 7'd0, 32'($urandom)};
    w2_flat  = {8'd0, 32'($urandom)};
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("[TB] FAIL %s busy_after_accept: got %b, expected 1", name, busy);
    end
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    nvec++;
    if (!seen || n != 24) begin
      nerr++;
      $display("[TB] FAIL %s latency: got %0d edges (seen=%b), expected 24", name, n, seen);
    end
    if (!seen) return;
    nvec++;
    if (out0 !== exp0) begin
      nerr++;
      $display("[TB] FAIL %s out0: got %0d, expected %0d", name, out0, exp0);
    end
    nvec++;
    if (out1 !== exp1) begin
      nerr++;
      $display("[TB] FAIL %s out1: got %0d, expected %0d", name, out1, exp1);
    end
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      x_flat   = 20'($urandom);
      @(posedge clk);
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out0 !== exp0 || out1 !== exp1) begin
        nerr++;
        $display("[TB] FAIL %s hold%0d: got valid=%b ready=%b out0=%0d out1=%0d, expected 1 0 %0d %0d",
                 name, c, out_valid, in_ready, out0, out1, exp0, exp1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL %s release: got valid=%b ready=%b busy=%b, expected 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if (out0 !== '0 || out1 !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_outs: got %0d %0d, expected 0 0", out0, out1);
    end
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL reset_ctrl: got valid=%b ready=%b busy=%b, expected 0 1 0",
               out_valid, in_ready, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL post_reset_idle: got ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_all_ones();
    longint t;
    run_job({4{5'd1}}, {16{5'd1}}, {8{5'd1}}, 16, 16, 0, "all_ones", t);
  endtask

  task automatic test_relu_clamp();
    longint t;
    run_job({4{5'd1}}, {16{5'h1f}}, {8{5'd7}}, 0, 0, 0, "relu_clamp", t);
  endtask

  task automatic test_extremes();
    longint t;
    run_job({4{5'h10}}, {16{5'h10}}, {8{5'h10}}, -65536, -65536, 0, "extreme_neg", t);
    run_job({4{5'h10}}, {16{5'h10}}, {8{5'd15}}, 61440, 61440, 0, "extreme_pos", t);
  endtask

  task automatic test_backpressure();
    longint t;
    run_job({4{5'd1}}, {16{5'd1}}, {8{5'd1}}, 16, 16, 10, "backpressure", t);
  endtask

  task automatic test_mixed_signs();
    logic [19:0] xf;
    logic [79:0] w1f;
    logic [39:0] w2f;
    int     o0, o1;
    longint t;
    xf = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w1f[(4*i+j)*5 +: 5] = (j == 0) ? 5'd1 : (j == 1) ? 5'h1f : (i == j) ? 5'd1 : 5'd0;
    for (int j = 0; j < 4; j++) begin
      w2f[(2*j)*5 +: 5]   = 5'd1;
      w2f[(2*j+1)*5 +: 5] = 5'h1f;
    end
    ref_model(xf, w1f, w2f, o0, o1);
    run_job(xf, w1f, w2f, o0, o1, 0, "mixed_signs", t);
  endtask

  task automatic test_back_to_back();
    logic [95:0] r;
    logic [19:0] xf;
    logic [79:0] w1f;
    logic [39:0] w2f;
    int     o0, o1;
    longint t, t_prev;
    t_prev = 0;
    for (int n = 0; n < 200; n++) begin
      r   = {$urandom, $urandom, $urandom};
      xf  = r[19:0];
      r   = {$urandom, $urandom, $urandom};
      w1f = r[79:0];
      r   = {$urandom, $urandom, $urandom};
      w2f = r[39:0];
      ref_model(xf, w1f, w2f, o0, o1);
      run_job(xf, w1f, w2f, o0, o1, 0, $sformatf("rand%0d", n), t);
      if (n > 0) begin
        nvec++;
        if ((t - t_prev) / 10 != 26) begin
          nerr++;
          $display("[TB] FAIL rand%0d spacing: got %0d cycles, expected 26", n, (t - t_prev) / 10);
        end
      end
      t_prev = t;
    end
  endtask

  task automatic test_mid_reset();
    longint t;
    int     o0, o1;
    logic [19:0] xf;
    logic [79:0] w1f;
    logic [39:0] w2f;
    run_job({4{5'd1}}, {16{5'd1}}, {8{5'd1}}, 16, 16, 0, "pre_reset", t);
    in_valid = 1'b1;
    x_flat   = {4{5'd2}};
    w1_flat  = {16{5'd3}};
    w2_flat  = {8{5'd1}};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (out0 !== '0 || out1 !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL mid_reset: got out0=%0d out1=%0d valid=%b ready=%b busy=%b, expected 0 0 0 1 0",
               out0, out1, out_valid, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xf  = {5'h1d, 5'd6, 5'h12, 5'd9};
    w1f = {$urandom, $urandom, 16'h5a3c};
    w2f = {8'h3e, $urandom};
    ref_model(xf, w1f, w2f, o0, o1);
    run_job(xf, w1f, w2f, o0, o1, 0, "after_reset", t);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_relu_clamp();
    test_extremes();
    test_backpressure();
    test_mixed_signs();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
